// File: rtl/duty_supervisor.sv
// Power-stage duty sequencer: soft-start ramp, regulation, soft-shutdown ramp and fault trip.
// One-cycle registered latency on all outputs; no backpressure, inputs are sampled every cycle.
module duty_supervisor #(
  parameter int DW       = 11,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 200,
  parameter int D_MIN    = 0,
  parameter int D_MAX    = 1000
) (
  input  logic          i_clk,
  input  logic          reset,
  input  logic          i_run,
  input  logic          i_fault,
  input  logic [DW-1:0] i_ss_target,
  input  logic [DW-1:0] i_comp_duty,
  input  logic          i_comp_valid,
  output logic [DW-1:0] o_duty,
  output logic          o_dpwm_en,
  output logic          o_comp_en,
  output logic [1:0]    o_state,
  output logic          o_ss_done,
  output logic          o_sd_done,
  output logic          o_fault
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    REGULATE  = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] STEP_W    = DW'(STEP);
  localparam logic [DW-1:0] DMIN_W    = DW'(D_MIN);
  localparam logic [DW-1:0] DMAX_W    = DW'(D_MAX);

  state_t        state;
  logic [TW-1:0] tick;
  logic [DW-1:0] target;

  logic          tick_hit;
  logic [DW:0]   up_sum;
  logic [DW-1:0] up_next;
  logic [DW-1:0] dn_next;
  logic [DW-1:0] comp_clamped;
  logic [DW-1:0] ss_capped;

  // Ramp arithmetic is one bit wider so an up-step can never wrap past the target.
  always_comb begin
    tick_hit     = (tick == TICK_LAST);
    up_sum       = {1'b0, o_duty} + {1'b0, STEP_W};
    up_next      = (up_sum >= {1'b0, target}) ? target : up_sum[DW-1:0];
    dn_next      = (o_duty > STEP_W) ? (o_duty - STEP_W) : '0;
    ss_capped    = (i_ss_target >= DMAX_W) ? DMAX_W : i_ss_target;
    comp_clamped = i_comp_duty;
    if (i_comp_duty <= DMIN_W)      comp_clamped = DMIN_W;
    else if (i_comp_duty >= DMAX_W) comp_clamped = DMAX_W;
  end

  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state     <= IDLE;
      tick      <= '0;
      target    <= '0;
      o_duty    <= '0;
      o_dpwm_en <= 1'b0;
      o_comp_en <= 1'b0;
      o_ss_done <= 1'b0;
      o_sd_done <= 1'b0;
      o_fault   <= 1'b0;
    end else begin
      o_ss_done <= 1'b0;
      o_sd_done <= 1'b0;
      if (i_fault) begin
        state     <= IDLE;
        tick      <= '0;
        o_duty    <= '0;
        o_dpwm_en <= 1'b0;
        o_comp_en <= 1'b0;
        o_fault   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            tick   <= '0;
            o_duty <= '0;
            // A latched fault must see i_run low before a new start is accepted.
            if (o_fault) begin
              if (!i_run) o_fault <= 1'b0;
            end else if (i_run) begin
              state     <= RAMP_UP;
              target    <= ss_capped;
              o_dpwm_en <= 1'b1;
            end
          end
          RAMP_UP: begin
            if (!i_run) begin
              state <= RAMP_DOWN;
              tick  <= '0;
            end else if (tick_hit) begin
              tick   <= '0;
              o_duty <= up_next;
              if (up_next == target) begin
                state     <= REGULATE;
                o_ss_done <= 1'b1;
                o_comp_en <= 1'b1;
              end
            end else begin
              tick <= tick + TW'(1);
            end
          end
          REGULATE: begin
            tick <= '0;
            if (!i_run) begin
              state     <= RAMP_DOWN;
              o_comp_en <= 1'b0;
            end else if (i_comp_valid) begin
              o_duty <= comp_clamped;
            end
          end
          RAMP_DOWN: begin
            if (tick_hit) begin
              tick   <= '0;
              o_duty <= dn_next;
              if (dn_next == '0) begin
                state     <= IDLE;
                o_sd_done <= 1'b1;
                o_dpwm_en <= 1'b0;
              end
            end else begin
              tick <= tick + TW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_duty_supervisor.sv
// Directed bench: instance a (STEP=2, TICK_DIV=4, D_MIN=50) and instance b (STEP=300, TICK_DIV=1).
module tb_duty_supervisor;

  localparam int DW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          a_reset, a_run, a_fault, a_comp_valid;
  logic [DW-1:0] a_ss_target, a_comp_duty, a_duty;
  logic          a_dpwm_en, a_comp_en, a_ss_done, a_sd_done, a_fault_o;
  logic [1:0]    a_state;

  logic          b_reset, b_run, b_fault, b_comp_valid;
  logic [DW-1:0] b_ss_target, b_comp_duty, b_duty;
  logic          b_dpwm_en, b_comp_en, b_ss_done, b_sd_done, b_fault_o;
  logic [1:0]    b_state;

  duty_supervisor #(.DW(DW), .STEP(2), .TICK_DIV(4), .D_MIN(50), .D_MAX(1000)) dut_a (
    .i_clk(clk), .reset(a_reset), .i_run(a_run), .i_fault(a_fault),
    .i_ss_target(a_ss_target), .i_comp_duty(a_comp_duty), .i_comp_valid(a_comp_valid),
    .o_duty(a_duty), .o_dpwm_en(a_dpwm_en), .o_comp_en(a_comp_en), .o_state(a_state),
    .o_ss_done(a_ss_done), .o_sd_done(a_sd_done), .o_fault(a_fault_o)
  );

  duty_supervisor #(.DW(DW), .STEP(300), .TICK_DIV(1), .D_MIN(0), .D_MAX(1000)) dut_b (
    .i_clk(clk), .reset(b_reset), .i_run(b_run), .i_fault(b_fault),
    .i_ss_target(b_ss_target), .i_comp_duty(b_comp_duty), .i_comp_valid(b_comp_valid),
    .o_duty(b_duty), .o_dpwm_en(b_dpwm_en), .o_comp_en(b_comp_en), .o_state(b_state),
    .o_ss_done(b_ss_done), .o_sd_done(b_sd_done), .o_fault(b_fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    a_reset = 1'b1; a_run = 1'b0; a_fault = 1'b0; a_comp_valid = 1'b0;
    a_ss_target = '0; a_comp_duty = '0;
    b_reset = 1'b1; b_run = 1'b0; b_fault = 1'b0; b_comp_valid = 1'b0;
    b_ss_target = '0; b_comp_duty = '0;
    step(2);

    chk("rst_a_duty", a_duty, 0);
    chk("rst_a_state", a_state, 0);
    chk("rst_a_dpwm", a_dpwm_en, 0);
    chk("rst_a_comp", a_comp_en, 0);
    chk("rst_a_fault", a_fault_o, 0);
    chk("rst_b_state", b_state, 0);
    a_reset = 1'b0; b_reset = 1'b0;

    // Soft start to 10 in steps of 2, one step every 4 cycles.
    a_ss_target = 11'd10; a_run = 1'b1;
    step(1);
    chk("ss_enter_state", a_state, 1);
    chk("ss_enter_dpwm", a_dpwm_en, 1);
    chk("ss_enter_duty", a_duty, 0);
    chk("ss_enter_comp", a_comp_en, 0);
    for (int k = 1; k <= 5; k++) begin
      step(3);
      chk($sformatf("ss_hold_%0d", k), a_duty, 2 * (k - 1));
      step(1);
      chk($sformatf("ss_duty_%0d", k), a_duty, 2 * k);
      chk($sformatf("ss_done_%0d", k), a_ss_done, (k == 5) ? 1 : 0);
    end
    chk("ss_reg_state", a_state, 2);
    chk("ss_reg_comp", a_comp_en, 1);
    step(1);
    chk("ss_done_clear", a_ss_done, 0);
    chk("ss_comp_hold", a_comp_en, 1);

    // Regulation with clamping to [50, 1000].
    a_comp_duty = 11'd20; a_comp_valid = 1'b1;
    step(1);
    a_comp_valid = 1'b0;
    chk("reg_clamp_lo", a_duty, 50);
    a_comp_duty = 11'd600;
    step(1);
    chk("reg_no_strobe", a_duty, 50);
    a_comp_valid = 1'b1;
    step(1);
    chk("reg_mid", a_duty, 600);
    a_comp_duty = 11'd2000;
    step(1);
    a_comp_valid = 1'b0;
    chk("reg_clamp_hi", a_duty, 1000);
    a_comp_duty = 11'd5;
    step(2);
    chk("reg_hold", a_duty, 1000);

    // Fault beats a simultaneous shutdown request.
    a_run = 1'b0; a_fault = 1'b1;
    step(1);
    a_fault = 1'b0;
    chk("fprio_state", a_state, 0);
    chk("fprio_duty", a_duty, 0);
    chk("fprio_fault", a_fault_o, 1);
    chk("fprio_sd_done", a_sd_done, 0);
    step(1);
    chk("fprio_clear", a_fault_o, 0);

    // Fault during soft start at duty 6, then clear and restart.
    a_ss_target = 11'd7; a_run = 1'b1;
    step(1);
    step(12);
    chk("fup_pre_duty", a_duty, 6);
    chk("fup_pre_state", a_state, 1);
    a_fault = 1'b1;
    step(1);
    a_fault = 1'b0;
    chk("fup_duty", a_duty, 0);
    chk("fup_state", a_state, 0);
    chk("fup_fault", a_fault_o, 1);
    chk("fup_dpwm", a_dpwm_en, 0);
    chk("fup_ss_done", a_ss_done, 0);
    step(3);
    chk("fup_sticky", a_fault_o, 1);
    chk("fup_stay_idle", a_state, 0);
    a_run = 1'b0;
    step(1);
    chk("fup_cleared", a_fault_o, 0);
    a_run = 1'b1;
    step(1);
    chk("restart_state", a_state, 1);
    chk("restart_duty", a_duty, 0);
    step(4); chk("rs_d2", a_duty, 2);
    step(4); chk("rs_d4", a_duty, 4);
    step(4); chk("rs_d6", a_duty, 6);
    step(4); chk("rs_d7", a_duty, 7);
    chk("rs_reg", a_state, 2);
    chk("rs_ss_done", a_ss_done, 1);

    // Shutdown from 7; a same-cycle strobe is dropped.
    a_comp_duty = 11'd600; a_comp_valid = 1'b1; a_run = 1'b0;
    step(1);
    a_comp_valid = 1'b0;
    chk("sd_state", a_state, 3);
    chk("sd_drop_sample", a_duty, 7);
    chk("sd_comp_off", a_comp_en, 0);
    chk("sd_dpwm_on", a_dpwm_en, 1);
    step(4); chk("sd_d5", a_duty, 5);
    a_run = 1'b1;
    step(2);
    a_run = 1'b0;
    chk("sd_ignore_run", a_state, 3);
    step(2); chk("sd_d3", a_duty, 3);
    step(4); chk("sd_d1", a_duty, 1);
    step(3);
    chk("sd_pre_zero", a_duty, 1);
    chk("sd_pre_done", a_sd_done, 0);
    step(1);
    chk("sd_d0", a_duty, 0);
    chk("sd_idle", a_state, 0);
    chk("sd_done", a_sd_done, 1);
    chk("sd_dpwm_off", a_dpwm_en, 0);
    step(1);
    chk("sd_done_clear", a_sd_done, 0);
    chk("sd_stay_idle", a_state, 0);

    // Instance b: target above D_MAX, step of 300 every cycle.
    b_ss_target = 11'd1500; b_run = 1'b1;
    step(1);
    chk("b_enter", b_state, 1);
    step(1); chk("b_d300", b_duty, 300);
    step(1); chk("b_d600", b_duty, 600);
    step(1); chk("b_d900", b_duty, 900);
    chk("b_d900_state", b_state, 1);
    step(1); chk("b_d1000", b_duty, 1000);
    chk("b_reg", b_state, 2);
    chk("b_ss_done", b_ss_done, 1);
    step(1); chk("b_hold", b_duty, 1000);

    // Reset asserted mid shutdown at duty 400.
    b_comp_duty = 11'd700; b_comp_valid = 1'b1;
    step(1);
    b_comp_valid = 1'b0;
    chk("b_reg700", b_duty, 700);
    b_run = 1'b0;
    step(1);
    chk("b_sd_state", b_state, 3);
    step(1);
    chk("b_sd400", b_duty, 400);
    b_reset = 1'b1;
    step(1);
    chk("b_rst_duty", b_duty, 0);
    chk("b_rst_state", b_state, 0);
    chk("b_rst_dpwm", b_dpwm_en, 0);
    chk("b_rst_comp", b_comp_en, 0);
    chk("b_rst_sd_done", b_sd_done, 0);
    chk("b_rst_ss_done", b_ss_done, 0);
    chk("b_rst_fault", b_fault_o, 0);
    b_reset = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
